// File: rtl/fcs_pkg.sv
// Shared types and width helpers for the stuck-at fault campaign sequencer.
package fcs_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_APPLY,
      ST_COMPARE,
      ST_REPORT,
      ST_NEXT,
      ST_DONE
   } fcs_state_t;

   localparam int FCS_SEL_NONE = 0;

   function automatic int fcs_sel_w(input int n_nodes);
      return $clog2(n_nodes + 1);
   endfunction

   // One spare bit so the counter can step past the last vector without wrapping.
   function automatic int fcs_vec_w(input int n_in);
      return n_in + 1;
   endfunction

   function automatic int fcs_cnt_w(input int n_nodes);
      return $clog2(2 * n_nodes + 1);
   endfunction

endpackage

// File: rtl/fcs_settle_timer.sv
// Loadable down-counter; expired pulses for one cycle SETTLE cycles after load.
module fcs_settle_timer #(
   parameter int SETTLE = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   output logic expired
);

   localparam int CW = $clog2(SETTLE + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= CW'(SETTLE);
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign expired = (cnt == CW'(1));

endmodule

// File: rtl/fault_campaign_seq.sv
// Stuck-at fault campaign sequencer: sweeps vectors x fault slots, compares DUT to golden.
// Optional FCS_FAULT_DROP_EN: already-detected faults are skipped for later vectors.
module fault_campaign_seq
   import fcs_pkg::*;
#(
   parameter int N_IN    = 5,
   parameter int N_OUT   = 2,
   parameter int N_NODES = 16,
   parameter int SETTLE  = 2
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                start,
   output logic                                busy,
   output logic                                done,
   output logic [N_IN-1:0]                     vec,
   output logic [fcs_sel_w(N_NODES)-1:0]       fault_sel,
   output logic                                fault_val,
   input  logic [N_OUT-1:0]                    dut_out,
   input  logic [N_OUT-1:0]                    gold_out,
   output logic                                det_valid,
   input  logic                                det_ready,
   output logic [N_IN-1:0]                     det_vec,
   output logic [fcs_sel_w(N_NODES)-1:0]       det_node,
   output logic                                det_sa,
   output logic [2*N_NODES-1:0]                fault_map,
   output logic [fcs_cnt_w(N_NODES)-1:0]       cov_count,
   output logic                                golden_err
);

   localparam int SEL_W  = fcs_sel_w(N_NODES);
   localparam int VEC_W  = fcs_vec_w(N_IN);
   localparam int N_SLOT = 2 * N_NODES;
   localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'((2 ** N_IN) - 1);
   localparam logic [SEL_W-1:0] SEL_NONE = SEL_W'(FCS_SEL_NONE);

   fcs_state_t       state, state_nxt;
   logic [VEC_W-1:0] vec_cnt;
   logic             expired, timer_load, start_acc, cmp_en, adv_en, hs;
   logic             mismatch, last_vec, wrap, skip;
   logic [SEL_W-1:0] nxt_sel;
   logic             nxt_sa;
   int               cur_k, map_idx;

   fcs_settle_timer #(.SETTLE(SETTLE)) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (timer_load),
      .expired (expired)
   );

   assign vec      = vec_cnt[N_IN-1:0];
   assign mismatch = (dut_out != gold_out);
   assign last_vec = (vec_cnt == VEC_LAST);

   // Slot k: 0 is fault-free, k>0 is node (k+1)/2 stuck at (k even).
   always_comb begin
      cur_k   = (fault_sel == SEL_NONE) ? 0 : 2 * int'(fault_sel) - 1 + int'(fault_val);
      map_idx = (cur_k == 0) ? 0 : cur_k - 1;
      wrap    = 1'b1;
      nxt_sel = '0;
      nxt_sa  = 1'b0;
      skip    = 1'b0;
      for (int k = 1; k <= N_SLOT; k++) begin
`ifdef FCS_FAULT_DROP_EN
         skip = fault_map[k-1];
`else
         skip = 1'b0;
`endif
         if (wrap && (k > cur_k) && !skip) begin
            wrap    = 1'b0;
            nxt_sel = SEL_W'((k + 1) / 2);
            nxt_sa  = ((k % 2) == 0);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE, ST_DONE: if (start) state_nxt = ST_APPLY;
         ST_APPLY:         if (expired) state_nxt = ST_COMPARE;
         ST_COMPARE:       state_nxt = (mismatch && fault_sel != SEL_NONE) ? ST_REPORT : ST_NEXT;
         ST_REPORT:        if (det_valid && det_ready) state_nxt = ST_NEXT;
         ST_NEXT:          state_nxt = (wrap && last_vec) ? ST_DONE : ST_APPLY;
         default:          state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      start_acc  = start && (state == ST_IDLE || state == ST_DONE);
      timer_load = (state_nxt == ST_APPLY) && (state != ST_APPLY);
      cmp_en     = (state == ST_COMPARE);
      adv_en     = (state == ST_NEXT);
      hs         = (state == ST_REPORT) && det_valid && det_ready;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec_cnt    <= '0;
         fault_sel  <= '0;
         fault_val  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         det_valid  <= 1'b0;
         det_vec    <= '0;
         det_node   <= '0;
         det_sa     <= 1'b0;
         fault_map  <= '0;
         cov_count  <= '0;
         golden_err <= 1'b0;
      end else begin
         if (start_acc) begin
            vec_cnt    <= '0;
            fault_sel  <= SEL_NONE;
            fault_val  <= 1'b0;
            fault_map  <= '0;
            cov_count  <= '0;
            golden_err <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b1;
            det_valid  <= 1'b0;
         end
         if (cmp_en && mismatch) begin
            if (fault_sel == SEL_NONE) begin
               golden_err <= 1'b1;
            end else begin
               if (!fault_map[map_idx]) begin
                  fault_map[map_idx] <= 1'b1;
                  cov_count          <= cov_count + 1'b1;
               end
               det_valid <= 1'b1;
               det_vec   <= vec;
               det_node  <= fault_sel;
               det_sa    <= fault_val;
            end
         end
         if (hs) det_valid <= 1'b0;
         if (adv_en) begin
            if (!wrap) begin
               fault_sel <= nxt_sel;
               fault_val <= nxt_sa;
            end else begin
               fault_sel <= SEL_NONE;
               fault_val <= 1'b0;
               vec_cnt   <= vec_cnt + 1'b1;
               if (last_vec) begin
                  busy <= 1'b0;
                  done <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_fault_campaign_seq.sv
// Scoreboard bench for fault_campaign_seq: behavioural campaign model vs DUT records and applied slots.
module tb_fault_campaign_seq;

   localparam int N_VEC  = 32;
   localparam int N_SLOT = 33;
   localparam int SETTLE = 2;
`ifdef FCS_FAULT_DROP_EN
   localparam bit DROP = 1'b1;
`else
   localparam bit DROP = 1'b0;
`endif

   typedef struct {
      int v;
      int sel;
      int sa;
   } slot_t;

   logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, det_ready = 1'b1;
   logic        busy, done, fault_val, det_valid, det_sa, golden_err;
   logic [4:0]  vec, fault_sel, det_vec, det_node;
   logic [1:0]  dut_out, gold_out;
   logic [31:0] fault_map;
   logic [5:0]  cov_count;

   bit          inj [N_VEC][N_SLOT];
   slot_t       rec_q[$];
   slot_t       app_q[$];
   logic [31:0] exp_map;
   int          exp_cov, n_app, n_rec;
   bit          exp_gerr;
   int          tests = 0, failed = 0;
   bit          chk_en = 1'b0, have_prev = 1'b0;
   logic [10:0] prev_slot;
   int          ready_mode = 0, stall_left = 0;

   fault_campaign_seq dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .vec        (vec),
      .fault_sel  (fault_sel),
      .fault_val  (fault_val),
      .dut_out    (dut_out),
      .gold_out   (gold_out),
      .det_valid  (det_valid),
      .det_ready  (det_ready),
      .det_vec    (det_vec),
      .det_node   (det_node),
      .det_sa     (det_sa),
      .fault_map  (fault_map),
      .cov_count  (cov_count),
      .golden_err (golden_err)
   );

   always #5 clk = ~clk;

   function automatic int slot_of(input logic [4:0] sel, input logic sa);
      if (sel == 5'd0) return 0;
      return 2 * int'(sel) - 1 + int'(sa);
   endfunction

   // Golden logic plus an injected output flip on the slots marked in inj.
   always_comb begin
      gold_out = vec[1:0] ^ vec[4:3];
      dut_out  = gold_out ^ {1'b0, inj[int'(vec)][slot_of(fault_sel, fault_val)]};
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic clear_inj();
      for (int v = 0; v < N_VEC; v++)
         for (int k = 0; k < N_SLOT; k++) inj[v][k] = 1'b0;
   endtask

   // Campaign outcome from the rules: slot order, drop policy, sticky flags.
   task automatic build_model();
      slot_t s;
      rec_q.delete();
      app_q.delete();
      exp_map  = '0;
      exp_gerr = 1'b0;
      n_app    = 0;
      n_rec    = 0;
      for (int v = 0; v < N_VEC; v++) begin
         for (int k = 0; k < N_SLOT; k++) begin
            if (!(DROP && k > 0 && exp_map[k-1])) begin
               s.v   = v;
               s.sel = (k + 1) / 2;
               s.sa  = (k > 0 && (k % 2) == 0) ? 1 : 0;
               app_q.push_back(s);
               n_app++;
               if (inj[v][k]) begin
                  if (k == 0) begin
                     exp_gerr = 1'b1;
                  end else begin
                     exp_map[k-1] = 1'b1;
                     rec_q.push_back(s);
                     n_rec++;
                  end
               end
            end
         end
      end
      exp_cov = $countones(exp_map);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0: det_ready = 1'b1;
            1: begin
               if (det_valid && stall_left > 0) begin
                  det_ready = 1'b0;
                  stall_left--;
               end else begin
                  det_ready = 1'b1;
               end
            end
            default: det_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // Monitor: every newly applied slot and every valid record against the queues.
   always @(negedge clk) begin
      slot_t       s;
      logic [10:0] cur;
      if (chk_en && rst_n) begin
         cur = {vec, fault_sel, fault_val};
         if (busy && (!have_prev || cur != prev_slot)) begin
            have_prev = 1'b1;
            prev_slot = cur;
            if (app_q.size() == 0) begin
               check("slot_extra", 64'(cur), 64'h7ff);
            end else begin
               s = app_q.pop_front();
               check("slot", 64'(cur), 64'({s.v[4:0], s.sel[4:0], s.sa[0]}));
            end
         end
         if (det_valid) begin
            if (rec_q.size() == 0) begin
               check("record_extra", 64'({det_vec, det_node, det_sa}), 64'h7ff);
            end else begin
               s = rec_q[0];
               check("record", 64'({det_vec, det_node, det_sa}), 64'({s.v[4:0], s.sel[4:0], s.sa[0]}));
               if (det_ready) void'(rec_q.pop_front());
            end
         end
      end
   end

   task automatic run_campaign(input string nm, input bit chk_cyc, input int stall, input int extra_start);
      int cyc;
      bit ok;
      build_model();
      have_prev = 1'b0;
      chk_en    = 1'b1;
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      cyc = 0;
      ok  = 1'b0;
      while (cyc < 20000) begin
         @(negedge clk);
         if (done) begin
            ok = 1'b1;
            break;
         end
         if (extra_start > 0 && cyc == extra_start) start = 1'b1;
         @(posedge clk);
         #1 start = 1'b0;
         cyc++;
      end
      chk_en = 1'b0;
      check({nm, "_finished"}, 64'(ok), 64'd1);
      check({nm, "_busy"}, 64'(busy), 64'd0);
      check({nm, "_golden_err"}, 64'(golden_err), 64'(exp_gerr));
      check({nm, "_fault_map"}, 64'(fault_map), 64'(exp_map));
      check({nm, "_cov_count"}, 64'(cov_count), 64'(exp_cov));
      check({nm, "_records_left"}, 64'(rec_q.size()), 64'd0);
      check({nm, "_slots_left"}, 64'(app_q.size()), 64'd0);
      if (chk_cyc) check({nm, "_cycles"}, 64'(cyc), 64'(n_app * (SETTLE + 2) + n_rec + stall));
   endtask

   task automatic check_reset_state(input string nm);
      check({nm, "_busy"}, 64'(busy), 64'd0);
      check({nm, "_done"}, 64'(done), 64'd0);
      check({nm, "_slot"}, 64'({vec, fault_sel, fault_val}), 64'd0);
      check({nm, "_det"}, 64'({det_valid, det_vec, det_node, det_sa}), 64'd0);
      check({nm, "_fault_map"}, 64'(fault_map), 64'd0);
      check({nm, "_cov_count"}, 64'(cov_count), 64'd0);
      check({nm, "_golden_err"}, 64'(golden_err), 64'd0);
   endtask

   initial begin
      int  cyc;
      bit  seen;
      clear_inj();
      repeat (3) @(posedge clk);
      #1 check_reset_state("reset");
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1 check_reset_state("idle");

      // Identity DUT: nothing detected.
      run_campaign("identity", 1'b1, 0, 0);

      // Single detection at (10110, 3, 1); a stray start mid-run is ignored.
      clear_inj();
      inj[22][6] = 1'b1;
      run_campaign("single", 1'b1, 0, 50);

      // Same stuck fault seen on vectors 6 and 22.
      inj[6][6] = 1'b1;
      run_campaign("repeat", 1'b1, 0, 0);

      // Backpressure for 7 cycles on the one record.
      clear_inj();
      inj[22][6] = 1'b1;
      ready_mode = 1;
      stall_left = 7;
      run_campaign("stall", 1'b1, 7, 0);
      ready_mode = 0;

      // Golden mismatch on the fault-free slot of vector 0.
      clear_inj();
      inj[0][0] = 1'b1;
      run_campaign("golden", 1'b1, 0, 0);

      // Random fault sets, fixed and random ready.
      for (int r = 0; r < 2; r++) begin
         clear_inj();
         for (int i = 0; i < 40; i++) inj[$urandom_range(0, 31)][$urandom_range(0, 32)] = 1'b1;
         ready_mode = (r == 0) ? 0 : 2;
         run_campaign((r == 0) ? "rand_rdy" : "rand_bp", (r == 0), 0, 100);
      end
      ready_mode = 0;

      // Reset in the middle of vector 9 with records and golden_err already set.
      clear_inj();
      inj[1][0] = 1'b1;
      inj[2][5] = 1'b1;
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      seen = 1'b0;
      for (cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         if (vec == 5'd9) begin
            seen = 1'b1;
            break;
         end
      end
      check("midrst_reached_vec9", 64'(seen), 64'd1);
      rst_n = 1'b0;
      #1 check_reset_state("midrst");
      @(negedge clk) rst_n = 1'b1;
      run_campaign("after_rst", 1'b1, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
